// File: rtl/dma_copy_pkg.sv
// Shared encodings for the DMA copy/fill engine: command mode values and FSM states.
package dma_copy_pkg;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/dma_copy_engine.sv
// Word-granular memory copy/fill engine with one outstanding request; COPY costs 3 cycles/word, FILL 1 (no stalls).
// Requests hold until mem_gnt; optional busy-cycle counter perf_cycles when DMA_COPY_PERF_EN is defined.
module dma_copy_engine
  import dma_copy_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMA_COPY_PERF_EN
  , output logic [31:0]     perf_cycles
`endif
);

  localparam int ALIGN_W = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  state_t             state;
  logic               mode_q;
  logic [ADDR_W-1:0]  src_ptr;
  logic [ADDR_W-1:0]  dst_ptr;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  fill_q;
  logic               abort_pend;
  logic               abort_now;
  logic               misaligned;
  logic [LEN_W-1:0]   words_inc;

  assign busy = (state == ST_RD_REQ) || (state == ST_RD_WAIT) || (state == ST_WR_REQ);
  assign done = (state == ST_DONE);

  // An abort seen in any earlier busy cycle still counts when the handshake finally completes.
  assign abort_now  = abort | abort_pend;
  assign misaligned = (dst_addr[ALIGN_W-1:0] != '0) ||
                      ((mode == MODE_COPY) && (src_addr[ALIGN_W-1:0] != '0));
  assign words_inc  = words_done + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_COPY;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      len_q      <= '0;
      fill_q     <= '0;
      abort_pend <= 1'b0;
      err        <= 1'b0;
      words_done <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (busy && abort) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            src_ptr    <= src_addr;
            dst_ptr    <= dst_addr;
            len_q      <= len;
            fill_q     <= fill_value;
            words_done <= '0;
            err        <= 1'b0;
            abort_pend <= 1'b0;
            if (misaligned) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else if (len == '0) begin
              state <= ST_DONE;
            end else if (mode == MODE_FILL) begin
              state     <= ST_WR_REQ;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dst_addr;
              mem_wdata <= fill_value;
            end else begin
              state    <= ST_RD_REQ;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= src_addr;
            end
          end
        end
        ST_RD_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid) begin
            if (abort_now) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              state     <= ST_WR_REQ;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dst_ptr;
              mem_wdata <= mem_rdata;
            end
          end
        end
        ST_WR_REQ: begin
          if (mem_gnt) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            dst_ptr    <= dst_ptr + STEP;
            src_ptr    <= src_ptr + STEP;
            words_done <= words_inc;
            // Completing the last word wins over a simultaneous abort.
            if (words_inc == len_q) begin
              state <= ST_DONE;
            end else if (abort_now) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else if (mode_q == MODE_FILL) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dst_ptr + STEP;
              mem_wdata <= fill_q;
            end else begin
              state    <= ST_RD_REQ;
              mem_req  <= 1'b1;
              mem_addr <= src_ptr + STEP;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_COPY_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
    end else if ((state == ST_IDLE) && start) begin
      perf_cycles <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_copy_engine.sv
// Randomized bench: memory responder, word-level reference model feeding a write/result scoreboard.
module tb_dma_copy_engine;
  import dma_copy_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic [31:0] fill_value;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef DMA_COPY_PERF_EN
  logic [31:0] perf_cycles;
`endif

  dma_copy_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .abort(abort), .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef DMA_COPY_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic err; int words; int lat; } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  logic [31:0] phys    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int wr_seen = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  bit gnt_rand = 0;
  bit rv_rand = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Memory responder: random or always-on grant, read data after a 1..3 cycle delay.
  initial begin : responder
    int rd_cnt;
    logic [31:0] rd_addr;
    rd_cnt = 0;
    rd_addr = 0;
    mem_gnt = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_cnt = 0;
        mem_rvalid = 0;
        mem_gnt = 0;
      end else begin
        mem_rvalid = 0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            mem_rvalid = 1;
            mem_rdata = phys_rd(rd_addr);
          end
        end
        mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_req && mem_gnt) begin
          if (mem_we) phys[mem_addr] = mem_wdata;
          else begin
            rd_addr = mem_addr;
            rd_cnt = rv_rand ? int'($urandom_range(1, 3)) : 1;
          end
        end
      end
    end
  end

  // Monitor: pops expected writes and completions as the DUT presents them.
  initial begin : monitor
    bit stall_prev;
    logic [65:0] prev_fields;
    wr_t w;
    res_t r;
    stall_prev = 0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) check("req_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_fields[64:0]});
        if (mem_req) req_cnt++;
        if (mem_req && mem_gnt && mem_we) begin
          wr_seen++;
          if (exp_wr.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 0);
          else begin
            w = exp_wr.pop_front();
            check("wr_addr", mem_addr, w.addr);
            check("wr_data", mem_wdata, w.data);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_res.size() == 0) check("unexpected_done", done, 0);
          else begin
            r = exp_res.pop_front();
            check("done_err", err, r.err);
            check("done_words", words_done, r.words);
            if (r.lat >= 0) check("done_latency", cyc - start_cyc, r.lat);
          end
        end
        stall_prev = mem_req && !mem_gnt;
        prev_fields = {mem_req, mem_we, mem_addr, mem_wdata};
      end
    end
  end

  // Reference model: word-by-word forward transfer, truncated at stop_at words on abort.
  task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic [31:0] f, input int stop_at, input bit fast);
    bit mis;
    int cnt;
    res_t r;
    logic [31:0] data;
    mis = (d[1:0] != 0) || (m == MODE_COPY && s[1:0] != 0);
    cnt = (mis || n == 0) ? 0 : ((stop_at >= 0 && stop_at < n) ? stop_at : n);
    for (int i = 0; i < cnt; i++) begin
      data = (m == MODE_FILL) ? f : ref_rd(s + 32'(4 * i));
      ref_mem[d + 32'(4 * i)] = data;
      exp_wr.push_back('{addr: d + 32'(4 * i), data: data});
    end
    r.err = mis || (cnt < n && !mis && n != 0);
    r.words = cnt;
    if (mis || n == 0) r.lat = 1;
    else r.lat = fast ? ((m == MODE_FILL) ? n + 1 : 3 * n + 1) : -1;
    exp_res.push_back(r);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = 16'(n); fill_value = f;
    start = 1;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    check("busy_rise", busy, (mis || n == 0) ? 1'b0 : 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (exp_res.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_res.size() != 0) begin
      check("done_timeout", exp_res.size(), 0);
      exp_res.delete();
    end
    check("writes_drained", exp_wr.size(), 0);
    exp_wr.delete();
  endtask

  task automatic wait_writes(input int base, input int n, input bit need_rd_wait);
    int k;
    k = 0;
    while (!((wr_seen - base) >= n && (!need_rd_wait || (busy && !mem_req))) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) check("progress_timeout", wr_seen - base, n);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int snap;
    int d0;
    reset_n = 0; start = 0; mode = 0; src_addr = 0; dst_addr = 0;
    len = 0; fill_value = 0; abort = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words_done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    gnt_rand = 0; rv_rand = 0;
    issue(MODE_FILL, 32'h0, 32'h100, 128, 32'd5, -1, 1);
    wait_done(1000);
`ifdef DMA_COPY_PERF_EN
    check("perf_fill", perf_cycles, 128);
`endif
    issue(MODE_COPY, 32'h100, 32'h300, 128, 32'd0, -1, 1);
    wait_done(2000);
    check("copy_last_word", phys_rd(32'h4FC), 5);

    snap = req_cnt;
    issue(MODE_COPY, 32'h100, 32'h200, 0, 32'd0, -1, 1);
    wait_done(20);
    issue(MODE_FILL, 32'h0, 32'h102, 4, 32'd7, -1, 1);
    wait_done(20);
    issue(MODE_COPY, 32'h101, 32'h200, 4, 32'd0, -1, 1);
    wait_done(20);
    check("no_access_reqs", req_cnt, snap);
    issue(MODE_FILL, 32'h103, 32'h600, 3, 32'hABCD, -1, 1);
    wait_done(50);

    gnt_rand = 1; rv_rand = 1;
    for (int t = 0; t < 10; t++) begin
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)) << 2, 32'($urandom_range(0, 511)) << 2,
            int'($urandom_range(1, 24)), $urandom, -1, 0);
      wait_done(3000);
    end

    base = wr_seen;
    issue(MODE_COPY, 32'h100, 32'h900, 20, 32'd0, 10, 0);
    wait_writes(base, 10, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done(3000);

    base = wr_seen;
    issue(MODE_COPY, 32'h300, 32'hA00, 20, 32'd0, -1, 0);
    wait_writes(base, 3, 0);
    mode = MODE_FILL; dst_addr = 32'h700; len = 16'd5; fill_value = 32'hDEAD; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(3000);

    base = wr_seen;
    issue(MODE_COPY, 32'hA00, 32'hC00, 40, 32'd0, -1, 0);
    wait_writes(base, 5, 0);
    reset_n = 0;
    exp_wr.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    d0 = done_cnt;
    snap = req_cnt;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_err", err, 0);
    check("post_rst_words", words_done, 0);
    check("post_rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
    repeat (20) @(negedge clk);
    check("post_rst_no_done", done_cnt, d0);
    check("post_rst_no_req", req_cnt, snap);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
